sram_arbiter_mc: RTL and testbench
==================================

SRAM_ARBITER_MC -- requirements
Module: sram_arbiter_mc

Interface
REQ-001 SHALL provide parameter NCH, default 3, number of requesting channels (2..8).
REQ-002 SHALL provide parameter AW, default 20, SRAM word address width.
REQ-003 SHALL provide parameter DW, default 16, SRAM data width; must be a multiple of 8.
REQ-004 SHALL provide parameter WAIT, default 3, number of ACCESS cycles (1..15).
REQ-005 SHALL have port clk200, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have ports SR_OE_n, SR_WE_n, output, 1 each, active-low SRAM strobes.
REQ-008 SHALL have port SR_BE_n, output, DW/8, active-low byte lanes (bit 0 = D[7:0]).
REQ-009 SHALL have port SR_A, output, AW, SRAM address.
REQ-010 SHALL have port SR_D, inout, DW, SRAM data.
REQ-011 SHALL have ports req and ack, input and output, NCH each, toggle handshake per channel.
REQ-012 SHALL have port read, input, NCH, 1 = read and 0 = write per channel.
REQ-013 SHALL have port addr, input, NCH*AW, packed per-channel addresses.
REQ-014 SHALL have port be, input, NCH*DW/8, packed active-high byte enables.
REQ-015 SHALL have port wdata, input, NCH*DW, packed write data.
REQ-016 SHALL have port rdata, output, NCH*DW, packed per-channel read data registers.

Function
REQ-017 Channel n SHALL be pending while req[n] != ack[n]; read, addr, be and wdata must be stable from the req toggle until ack toggles.
REQ-018 State machine SHALL be IDLE -> SETUP -> ACCESS (WAIT cycles) -> DONE -> IDLE, with no other transitions except reset.
REQ-019 IDLE with any channel pending SHALL select one winner and register: SR_A=addr, SR_BE_n=~be, SR_OE_n=!read, SR_WE_n=1, drive off; then go to SETUP.
REQ-020 IDLE with nothing pending SHALL hold all strobes and byte lanes high and drive off.
REQ-021 SETUP on a write SHALL set SR_WE_n=0 and enable drive of wdata; on a read SHALL change nothing. It SHALL then go to ACCESS with the wait counter loaded.
REQ-022 ACCESS SHALL hold all outputs for exactly WAIT cycles, then go to DONE.
REQ-023 DONE read SHALL capture SR_D into rdata[winner] and toggle ack[winner]; other channels' rdata SHALL be unchanged.
REQ-024 DONE write SHALL set SR_WE_n=1 and keep drive on for this cycle (hold time), then release drive in IDLE; it SHALL toggle ack[winner].
REQ-025 Latency SHALL be: req toggle sampled at IDLE edge E0 -> ack toggles at edge E0+WAIT+3, with rdata valid in the same cycle. Back-to-back grant SHALL occur at the next IDLE edge.
REQ-026 Default priority SHALL be fixed, with the lowest index winning.
REQ-027 A req toggle arriving during a busy access SHALL wait; no request is lost or reordered within its channel.
REQ-028 SR_WE_n and SR_OE_n SHALL never be low simultaneously.

Reset
REQ-029 rst SHALL force state=IDLE, ack=0, rdata=0, SR_A=0, strobes and byte lanes high, drive off, and the RR pointer to 0, including mid-access; requesters must reset req to 0 with it.

Configuration
REQ-030 With SRAM_ARB_RR_EN defined, arbitration SHALL be round-robin: search starts at (last winner+1) mod NCH. Without it, fixed priority per REQ-026 applies and there is no pointer register.

Structure
REQ-031 Package sram_arb_pkg SHALL hold the state enum (IDLE, SETUP, ACCESS, DONE) and the WAIT counter width constant.
REQ-032 Winner selection SHALL be a sub-module sram_arb_pick (pending vector, pointer -> one-hot winner plus index), combinational only.

Verification
REQ-033 NCH=3, WAIT=3: ch1 write addr 0x00010, be=2'b11, wdata 0xA55A -> WE_n low 3+1 cycles, ack[1] toggles at E0+6.
REQ-034 Then ch1 read addr 0x00010 -> rdata[1]=0xA55A at ack toggle, OE_n low 5 cycles, rdata[0] and rdata[2] unchanged.
REQ-035 ch0 and ch2 toggle in the same cycle (fixed) -> ch0 is served first and ch2 at the next grant. With SRAM_ARB_RR_EN and last winner 0 -> ch2 is served first.
REQ-036 ch2 write be=2'b10, wdata 0x1234 to a location holding 0xFFFF, then read back -> 0x12FF.
REQ-037 rst asserted during ACCESS of a ch0 write -> next cycle WE_n=1, drive off, ack=0, and SR_D high-Z.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types for the multi-channel SRAM arbiter: FSM state encoding and wait counter width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sram_arb_pkg;

    // Access sequence: IDLE -> SETUP -> ACCESS (WAIT cycles) -> DONE -> IDLE
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Wide enough for WAIT up to 15
    localparam int WCNT_W = 4;

endpackage

// File: rtl/sram_arb_pick.sv
// Winner selection: first pending channel found searching upward from ptr, wrapping at NCH.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller only samples the result when it is ready to grant.
// Ports: pend (pending vector), ptr (search start index) -> win_oh (one-hot winner),
//        win_idx (winner index), any (at least one channel pending).
module sram_arb_pick #(
    parameter int NCH = 3,
    parameter int IW  = 2
) (
    input  logic [NCH-1:0] pend,
    input  logic [IW-1:0]  ptr,
    output logic [NCH-1:0] win_oh,
    output logic [IW-1:0]  win_idx,
    output logic           any
);

    int   idx;
    logic found;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < NCH; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NCH) idx = idx - NCH;
            if (!found && pend[idx]) begin
                found       = 1'b1;
                win_oh[idx] = 1'b1;
                win_idx     = IW'(idx);
            end
        end
        any = found;
    end

endmodule

// File: rtl/sram_arbiter_mc.sv
// Multi-channel asynchronous SRAM arbiter with per-channel toggle req/ack handshake.
// Latency: grant at IDLE edge E0, ack toggles at E0+WAIT+2 (WAIT+3 edges counting E0 as the first).
// Backpressure: a channel stays pending (req != ack) until served; one access in flight at a time.
// Ports: clk200/rst (sync active-high); SR_* SRAM pins (SR_D bidirectional);
//        per channel packed req/ack/read/addr/be/wdata/rdata.
// Config: define SRAM_ARB_RR_EN for round-robin arbitration; default is fixed priority (ch0 highest).
module sram_arbiter_mc
    import sram_arb_pkg::*;
#(
    parameter int NCH  = 3,
    parameter int AW   = 20,
    parameter int DW   = 16,
    parameter int WAIT = 3
) (
    input  logic                  clk200,
    input  logic                  rst,
    output logic                  SR_OE_n,
    output logic                  SR_WE_n,
    output logic [DW/8-1:0]       SR_BE_n,
    output logic [AW-1:0]         SR_A,
    inout  wire  [DW-1:0]         SR_D,
    input  logic [NCH-1:0]        req,
    output logic [NCH-1:0]        ack,
    input  logic [NCH-1:0]        read,
    input  logic [NCH*AW-1:0]     addr,
    input  logic [NCH*DW/8-1:0]   be,
    input  logic [NCH*DW-1:0]     wdata,
    output logic [NCH*DW-1:0]     rdata
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int BW = DW / 8;

    state_t             state;
    logic [WCNT_W-1:0]  cnt;
    logic [NCH-1:0]     pend;
    logic [NCH-1:0]     win_oh, win_oh_q;
    logic [IW-1:0]      win_idx, win_idx_q;
    logic [IW-1:0]      ptr;
    logic               any;
    logic               rd_q;
    logic               drive;
    logic [DW-1:0]      dout_q;

    assign pend = req ^ ack;

`ifdef SRAM_ARB_RR_EN
    logic [IW-1:0] rr_ptr;
    assign ptr = rr_ptr;
`else
    assign ptr = '0;
`endif

    sram_arb_pick #(
        .NCH (NCH),
        .IW  (IW)
    ) u_pick (
        .pend    (pend),
        .ptr     (ptr),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .any     (any)
    );

    // Write data is registered at grant so the bus value cannot glitch with the input mux
    assign SR_D = drive ? dout_q : {DW{1'bz}};

    always_ff @(posedge clk200) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ack       <= '0;
            rdata     <= '0;
            SR_A      <= '0;
            SR_OE_n   <= 1'b1;
            SR_WE_n   <= 1'b1;
            SR_BE_n   <= '1;
            drive     <= 1'b0;
            rd_q      <= 1'b0;
            dout_q    <= '0;
            win_oh_q  <= '0;
            win_idx_q <= '0;
`ifdef SRAM_ARB_RR_EN
            rr_ptr    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // Releases write drive one cycle after WE_n rose (hold time)
                    drive   <= 1'b0;
                    SR_WE_n <= 1'b1;
                    if (any) begin
                        win_oh_q  <= win_oh;
                        win_idx_q <= win_idx;
                        rd_q      <= read[win_idx];
                        SR_A      <= addr[win_idx*AW +: AW];
                        SR_BE_n   <= ~be[win_idx*BW +: BW];
                        SR_OE_n   <= ~read[win_idx];
                        dout_q    <= wdata[win_idx*DW +: DW];
`ifdef SRAM_ARB_RR_EN
                        rr_ptr    <= (win_idx == IW'(NCH - 1)) ? '0 : win_idx + 1'b1;
`endif
                        state     <= SETUP;
                    end else begin
                        SR_OE_n <= 1'b1;
                        SR_BE_n <= '1;
                    end
                end
                SETUP: begin
                    if (!rd_q) begin
                        SR_WE_n <= 1'b0;
                        drive   <= 1'b1;
                    end
                    cnt   <= WCNT_W'(WAIT - 1);
                    state <= ACCESS;
                end
                ACCESS: begin
                    if (cnt == '0) state <= DONE;
                    else           cnt   <= cnt - 1'b1;
                end
                DONE: begin
                    // OE_n is still low here, so SR_D carries the read data
                    if (rd_q) rdata[win_idx_q*DW +: DW] <= SR_D;
                    SR_WE_n <= 1'b1;
                    SR_OE_n <= 1'b1;
                    ack     <= ack ^ win_oh_q;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter_mc.sv
// Self-checking bench for sram_arbiter_mc with a behavioural byte-lane SRAM model.
// Latency: n/a.
// Backpressure: n/a.
module tb_sram_arbiter_mc;

    localparam int NCH  = 3;
    localparam int AW   = 20;
    localparam int DW   = 16;
    localparam int WAIT = 3;
    localparam int BW   = DW / 8;

    logic                clk200 = 1'b0;
    logic                rst;
    logic                SR_OE_n, SR_WE_n;
    logic [BW-1:0]       SR_BE_n;
    logic [AW-1:0]       SR_A;
    wire  [DW-1:0]       SR_D;
    logic [NCH-1:0]      req, ack, read;
    logic [NCH*AW-1:0]   addr;
    logic [NCH*BW-1:0]   be;
    logic [NCH*DW-1:0]   wdata, rdata;

    always #5 clk200 = ~clk200;

    sram_arbiter_mc #(.NCH(NCH), .AW(AW), .DW(DW), .WAIT(WAIT)) dut (
        .clk200 (clk200), .rst (rst),
        .SR_OE_n(SR_OE_n), .SR_WE_n(SR_WE_n), .SR_BE_n(SR_BE_n),
        .SR_A   (SR_A), .SR_D (SR_D),
        .req    (req), .ack (ack), .read (read),
        .addr   (addr), .be (be), .wdata (wdata), .rdata (rdata)
    );

    // SRAM model: drives the bus while OE_n is low, writes enabled lanes while WE_n is low
    logic [DW-1:0] mem [0:255];
    assign SR_D = (SR_OE_n == 1'b0) ? mem[SR_A[7:0]] : {DW{1'bz}};
    always @(posedge clk200) begin
        if (SR_WE_n == 1'b0) begin
            for (int b = 0; b < BW; b++)
                if (!SR_BE_n[b]) mem[SR_A[7:0]][b*8 +: 8] <= SR_D[b*8 +: 8];
        end
    end

    int both_low = 0;
    always @(negedge clk200)
        if (rst === 1'b0 && SR_WE_n === 1'b0 && SR_OE_n === 1'b0) both_low++;

    int n_tests = 0;
    int n_fail  = 0;
    logic [NCH*DW-1:0] exp_rd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          ch;
        logic        rd;
        logic [19:0] a;
        logic [1:0]  b;
        logic [15:0] wd;
        logic [15:0] exp_rdata;
        int          exp_lat;
        int          exp_we;
        int          exp_oe;
    } vec_t;

    task automatic drive_req(input int ch, input logic rd, input logic [19:0] a,
                             input logic [1:0] b, input logic [15:0] wd);
        read[ch]           = rd;
        addr[ch*AW +: AW]  = a;
        be[ch*BW +: BW]    = b;
        wdata[ch*DW +: DW] = wd;
        req[ch]            = ~req[ch];
    endtask

    // Edge count starts at 1 on the edge that samples the req toggle
    task automatic do_txn(input vec_t v, input string tag);
        int lat, we_c, oe_c;
        lat = 0; we_c = 0; oe_c = 0;
        @(negedge clk200);
        drive_req(v.ch, v.rd, v.a, v.b, v.wd);
        while (1) begin
            @(posedge clk200); #1;
            lat++;
            if (SR_WE_n == 1'b0) we_c++;
            if (SR_OE_n == 1'b0) oe_c++;
            if (ack[v.ch] == req[v.ch] || lat > 40) break;
        end
        if (v.rd) exp_rd[v.ch*DW +: DW] = v.exp_rdata;
        check({tag, "_lat"}, 64'(lat), 64'(v.exp_lat));
        check({tag, "_we_low"}, 64'(we_c), 64'(v.exp_we));
        check({tag, "_oe_low"}, 64'(oe_c), 64'(v.exp_oe));
        check({tag, "_rdata"}, 64'(rdata), 64'(exp_rd));
    endtask

    vec_t vecs [8];

    initial begin
        int t_first, t_second, ta, tb2;
        vec_t v;

        //          ch rd  addr      be     wdata     exp_rd    lat we oe
        vecs[0] = '{1, 0, 20'h00010, 2'b11, 16'hA55A, 16'h0000, 6, 4, 0};
        vecs[1] = '{1, 1, 20'h00010, 2'b00, 16'h0000, 16'hA55A, 6, 0, 5};
        vecs[2] = '{2, 0, 20'h00020, 2'b11, 16'hFFFF, 16'h0000, 6, 4, 0};
        vecs[3] = '{2, 0, 20'h00020, 2'b10, 16'h1234, 16'h0000, 6, 4, 0};
        vecs[4] = '{2, 1, 20'h00020, 2'b11, 16'h0000, 16'h12FF, 6, 0, 5};
        vecs[5] = '{2, 1, 20'h00010, 2'b11, 16'h0000, 16'hA55A, 6, 0, 5};
        vecs[6] = '{0, 0, 20'h00030, 2'b11, 16'hBEEF, 16'h0000, 6, 4, 0};
        vecs[7] = '{0, 1, 20'h00030, 2'b11, 16'h0000, 16'hBEEF, 6, 0, 5};

        rst = 1'b1; req = '0; read = '0; addr = '0; be = '0; wdata = '0;
        exp_rd = '0;
        repeat (3) @(posedge clk200);
        #1;
        check("rst_ack", 64'(ack), 64'(0));
        check("rst_rdata", 64'(rdata), 64'(0));
        check("rst_sr_a", 64'(SR_A), 64'(0));
        check("rst_we_n", 64'(SR_WE_n), 64'(1));
        check("rst_oe_n", 64'(SR_OE_n), 64'(1));
        check("rst_be_n", 64'(SR_BE_n), 64'(2'b11));
        check("rst_sr_d_z", 64'(SR_D === 16'hzzzz), 64'(1));
        @(negedge clk200);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            do_txn(vecs[i], $sformatf("v%0d", i));

        // Simultaneous toggles on ch0 and ch2; last winner was ch0
        @(negedge clk200);
        drive_req(0, 1'b1, 20'h00020, 2'b11, 16'h0000);
        drive_req(2, 1'b1, 20'h00030, 2'b11, 16'h0000);
        ta = 0; tb2 = 0;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk200); #1;
            if (ta == 0 && ack[0] == req[0]) ta = e;
            if (tb2 == 0 && ack[2] == req[2]) tb2 = e;
            if (ta != 0 && tb2 != 0) break;
        end
`ifdef SRAM_ARB_RR_EN
        t_first = tb2; t_second = ta;
`else
        t_first = ta; t_second = tb2;
`endif
        check("simul_first_lat", 64'(t_first), 64'(6));
        check("simul_second_lat", 64'(t_second), 64'(12));
        exp_rd[0*DW +: DW] = 16'h12FF;
        exp_rd[2*DW +: DW] = 16'hBEEF;
        check("simul_rdata", 64'(rdata), 64'(exp_rd));

        // Request arriving while another access is busy must wait, not be lost
        @(negedge clk200);
        drive_req(1, 1'b0, 20'h00050, 2'b11, 16'h5A5A);
        repeat (2) @(negedge clk200);
        drive_req(0, 1'b1, 20'h00050, 2'b11, 16'h0000);
        ta = 0; tb2 = 0;
        for (int e = 3; e <= 60; e++) begin
            @(posedge clk200); #1;
            if (ta == 0 && ack[1] == req[1]) ta = e;
            if (tb2 == 0 && ack[0] == req[0]) tb2 = e;
            if (ta != 0 && tb2 != 0) break;
        end
        check("busy_ch1_lat", 64'(ta), 64'(6));
        check("busy_ch0_lat", 64'(tb2), 64'(12));
        exp_rd[0*DW +: DW] = 16'h5A5A;
        check("busy_rdata", 64'(rdata), 64'(exp_rd));

        // Reset during ACCESS of a ch0 write
        @(negedge clk200);
        drive_req(0, 1'b0, 20'h00040, 2'b11, 16'h7777);
        repeat (3) @(posedge clk200);
        #1;
        check("pre_rst_we_n", 64'(SR_WE_n), 64'(0));
        @(negedge clk200);
        rst = 1'b1; req = '0;
        @(posedge clk200); #1;
        check("midrst_we_n", 64'(SR_WE_n), 64'(1));
        check("midrst_oe_n", 64'(SR_OE_n), 64'(1));
        check("midrst_be_n", 64'(SR_BE_n), 64'(2'b11));
        check("midrst_sr_d_z", 64'(SR_D === 16'hzzzz), 64'(1));
        check("midrst_ack", 64'(ack), 64'(0));
        check("midrst_rdata", 64'(rdata), 64'(0));
        @(negedge clk200);
        rst = 1'b0;
        exp_rd = '0;

        v = '{1, 1, 20'h00010, 2'b11, 16'h0000, 16'hA55A, 6, 0, 5};
        do_txn(v, "post_rst");

        check("strobes_never_both_low", 64'(both_low), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
